window_fetch_ctrl: RTL
======================

WINDOW_FETCH_CTRL -- requirements
Module: window_fetch_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, pixel width in bits.
REQ-002 Parameter TIMEOUT, default 255, maximum cycles to wait on any single handshake before error.
REQ-003 The block SHALL have a clock clk and reset n_rst (asynchronous, active-low).
REQ-004 Ports (name  dir  width  meaning):
- clk  in  1  clock
- n_rst  in  1  async active-low reset
- i_start  in  1  one-cycle pulse to begin a frame
- i_img_width  in  16  frame width in pixels
- i_img_height  in  16  frame height in pixels
- o_inc_raddr  out  1  one-cycle request to the address counter for the next read address
- i_r_ready  in  1  one-cycle pulse; read address is valid
- o_mem_ren  out  1  one-cycle memory read strobe
- i_rdata_valid  in  1  memory read data valid
- i_rdata  in  DATA_W  memory read data
- o_window  out  9*DATA_W  3x3 window, row-major, p0 in LSBs
- o_window_valid  out  1  one-cycle pulse; o_window complete
- i_result_valid  in  1  filter result valid
- i_result  in  DATA_W  filter output pixel
- o_inc_waddr  out  1  one-cycle request for the next write address
- i_w_ready  in  1  one-cycle pulse; write address is valid
- o_mem_wen  out  1  one-cycle memory write strobe
- o_wdata  out  DATA_W  write data
- o_busy  out  1  frame in progress
- o_done  out  1  one-cycle pulse; last output pixel written
- o_err  out  1  sticky handshake timeout

Function
REQ-005 Window count N SHALL be (i_img_width-2)*(i_img_height-2), 32-bit, latched when i_start is accepted in IDLE.
REQ-006 FSM states SHALL be IDLE, RREQ, RWAIT, MREAD, DWAIT, WIN, RES_WAIT, WREQ, WWAIT, MWRITE, DONE, ERR.
REQ-007 IDLE->RREQ on i_start; i_start is ignored outside IDLE.
REQ-008 RREQ SHALL assert o_inc_raddr for exactly one cycle, then go to RWAIT.
REQ-009 RWAIT->MREAD on i_r_ready; MREAD SHALL assert o_mem_ren for one cycle, then go to DWAIT.
REQ-010 DWAIT on i_rdata_valid SHALL store i_rdata into window slot k (k=0..8, incrementing); if k==8, go to WIN, else go to RREQ.
REQ-011 WIN SHALL pulse o_window_valid for one cycle, with o_window stable from that cycle until the next slot write, then go to RES_WAIT.
REQ-012 RES_WAIT->WREQ on i_result_valid, capturing i_result into o_wdata.
REQ-013 WREQ SHALL pulse o_inc_waddr; WWAIT->MWRITE on i_w_ready; MWRITE SHALL pulse o_mem_wen with o_wdata held.
REQ-014 After MWRITE the window counter SHALL increment; if it equals N go to DONE, else go to RREQ with k=0.
REQ-015 DONE SHALL pulse o_done for one cycle and return to IDLE.
REQ-016 o_busy SHALL be 1 in every state except IDLE, DONE and ERR.
REQ-017 Every wait state (RWAIT, DWAIT, RES_WAIT, WWAIT) SHALL count cycles; reaching TIMEOUT SHALL go to ERR and set o_err.
REQ-018 ERR SHALL be left only by reset.
REQ-019 Handshake inputs arriving in states that do not wait on them SHALL be ignored.
REQ-020 If N==0 (width or height <3), i_start SHALL go directly to DONE with no memory access.
REQ-021 Minimum latency per window SHALL be 9*4 read cycles, plus 1 WIN cycle, plus 4 write cycles when all responses arrive the cycle after each request.

Reset
REQ-022 On n_rst low: state=IDLE; all strobes, o_busy, o_done and o_err = 0; o_window, o_wdata, k and the window counter = 0.
REQ-023 Reset mid-frame SHALL abort immediately with no further strobes.

Structure
REQ-024 The state enum and the default DATA_W and TIMEOUT values SHALL live in a shared package, edge_pkg.
REQ-025 The nine-slot window register file SHALL be a sub-module, window_regs (write enable, index, data; flat output).

Verification
REQ-026 Bench SHALL cover the following scenarios:
- 4x4 frame, ideal one-cycle responders -> N=4; 36 reads and 4 writes per... total 36 o_mem_ren, 4 o_mem_wen, o_done once.
- Window data 1..9 -> o_window equals {9,...,1} at o_window_valid.
- i_r_ready withheld 255 cycles -> o_err=1, state ERR; o_busy=0.
- i_start during busy, or stray i_w_ready in RWAIT -> no effect on counts.
- Width 2 -> o_done one cycle after i_start, zero strobes.
- n_rst asserted in DWAIT -> all outputs 0 and a clean restart on the next i_start.

Source files
------------

// File: rtl/edge_pkg.sv
// edge_pkg: shared state encoding, defaults and window-count helper for the window fetch controller
package edge_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_TIMEOUT = 255;
  typedef enum logic [3:0] {
    IDLE, RREQ, RWAIT, MREAD, DWAIT, WIN, RES_WAIT, WREQ, WWAIT, MWRITE, DONE, ERR
  } state_t;
  function automatic logic [31:0] win_count(input logic [15:0] w, input logic [15:0] h);
    return (w < 16'd3 || h < 16'd3) ? 32'd0 : 32'(w - 16'd2) * 32'(h - 16'd2);
  endfunction
endpackage

// File: rtl/window_regs.sv
// window_regs: nine-slot 3x3 window register file with a flat row-major output
module window_regs #(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                we,
  input  logic [3:0]          idx,
  input  logic [DATA_W-1:0]   wdata,
  output logic [9*DATA_W-1:0] window
);
  for (genvar i = 0; i < 9; i++) begin : g_slot
    // each slot loads only when its index is addressed
    always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) window[i*DATA_W +: DATA_W] <= '0;
      else if (we && idx == 4'(i)) window[i*DATA_W +: DATA_W] <= wdata;
  end
endmodule

// File: rtl/window_fetch_ctrl.sv
// window_fetch_ctrl: fetches 3x3 windows from memory, hands them to a filter and writes results back
module window_fetch_ctrl
  import edge_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                i_start,
  input  logic [15:0]         i_img_width,
  input  logic [15:0]         i_img_height,
  output logic                o_inc_raddr,
  input  logic                i_r_ready,
  output logic                o_mem_ren,
  input  logic                i_rdata_valid,
  input  logic [DATA_W-1:0]   i_rdata,
  output logic [9*DATA_W-1:0] o_window,
  output logic                o_window_valid,
  input  logic                i_result_valid,
  input  logic [DATA_W-1:0]   i_result,
  output logic                o_inc_waddr,
  input  logic                i_w_ready,
  output logic                o_mem_wen,
  output logic [DATA_W-1:0]   o_wdata,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state, nxt;
  logic [3:0] k;
  logic [31:0] n_win, win_cnt;
  logic [CW-1:0] wait_cnt;
  logic timeout, slot_we;
  assign timeout = wait_cnt == CW'(TIMEOUT - 1);
  assign slot_we = state == DWAIT && i_rdata_valid;
  window_regs #(.DATA_W(DATA_W)) u_regs (
    .clk(clk), .n_rst(n_rst), .we(slot_we), .idx(k), .wdata(i_rdata), .window(o_window)
  );
  // state register
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) state <= IDLE;
    else state <= nxt;
  // next-state: each wait state gives up after TIMEOUT cycles without its handshake
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     if (i_start) nxt = win_count(i_img_width, i_img_height) == 32'd0 ? DONE : RREQ;
      RREQ:     nxt = RWAIT;
      RWAIT:    nxt = i_r_ready ? MREAD : timeout ? ERR : RWAIT;
      MREAD:    nxt = DWAIT;
      DWAIT:    nxt = i_rdata_valid ? (k == 4'd8 ? WIN : RREQ) : timeout ? ERR : DWAIT;
      WIN:      nxt = RES_WAIT;
      RES_WAIT: nxt = i_result_valid ? WREQ : timeout ? ERR : RES_WAIT;
      WREQ:     nxt = WWAIT;
      WWAIT:    nxt = i_w_ready ? MWRITE : timeout ? ERR : WWAIT;
      MWRITE:   nxt = win_cnt + 32'd1 == n_win ? DONE : RREQ;
      DONE:     nxt = IDLE;
      ERR:      nxt = ERR;
      default:  nxt = IDLE;
    endcase
  end
  // strobes decode straight from the state so reset silences them at once
  always_comb begin
    o_inc_raddr    = state == RREQ;
    o_mem_ren      = state == MREAD;
    o_window_valid = state == WIN;
    o_inc_waddr    = state == WREQ;
    o_mem_wen      = state == MWRITE;
    o_done         = state == DONE;
    o_err          = state == ERR;
    o_busy         = !(state == IDLE || state == DONE || state == ERR);
  end
  // frame bookkeeping: window target, progress, slot index, wait timer and result capture
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      k        <= '0;
      n_win    <= '0;
      win_cnt  <= '0;
      wait_cnt <= '0;
      o_wdata  <= '0;
    end else begin
      wait_cnt <= nxt != state ? '0 : wait_cnt + 1'b1;
      if (state == IDLE && i_start) begin
        n_win   <= win_count(i_img_width, i_img_height);
        win_cnt <= '0;
        k       <= '0;
      end
      if (slot_we) k <= k == 4'd8 ? 4'd0 : k + 4'd1;
      if (state == RES_WAIT && i_result_valid) o_wdata <= i_result;
      if (state == MWRITE) win_cnt <= win_cnt + 32'd1;
    end
endmodule
